snap_capture_ctrl: RTL and testbench

Capture controller in the user clock domain for an ADC snapshot channel such as adcsnap0. It arms from a software control word and waits for an immediate or external trigger. It then writes consecutive valid ADC samples into the snapshot BRAM and produces the 32-bit status word that feeds the snapshot status software register's user_data_in, so software can see the done flag and the word count.

---
 rtl/snap_pkg.sv | 22 ++
 rtl/snap_capture_ctrl_if.sv | 30 +++
 rtl/snap_edge_det.sv | 31 +++
 rtl/snap_capture_ctrl.sv | 112 +++++++++++
 tb/tb_snap_capture_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/snap_pkg.sv
// Shared definitions for the ADC snapshot capture controller.
//   state_e     : capture FSM states
//   CTRL_*      : bit positions in the software control word
//   ST_*        : flag bit positions in the status word
package snap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDone
    } state_e;

    localparam int unsigned CTRL_ARM  = 0;
    localparam int unsigned CTRL_TSRC = 1;
    localparam int unsigned CTRL_STOP = 2;

    localparam int unsigned ST_DONE = 31;
    localparam int unsigned ST_BUSY = 30;
    localparam int unsigned ST_TRIG = 29;

endpackage

// File: rtl/snap_capture_ctrl_if.sv
// Bundle of the capture controller's control, sample and BRAM-write signals.
//   ctrl_in    : software control word (arm / trig_src / stop)
//   trig_in    : external trigger, level-sampled
//   din        : ADC sample, qualified by din_valid
//   bram_*     : registered BRAM write port
//   status_out : status word for the status register
// Modport master drives control and samples; modport slave is the controller.
interface snap_capture_ctrl_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 64
);
    logic [31:0]       ctrl_in;
    logic              trig_in;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status_out;

    modport master (
        output ctrl_in, trig_in, din, din_valid,
        input  bram_addr, bram_data, bram_we, status_out
    );

    modport slave (
        input  ctrl_in, trig_in, din, din_valid,
        output bram_addr, bram_data, bram_we, status_out
    );
endinterface

// File: rtl/snap_edge_det.sv
// Rising-edge detector for the arm and stop control bits.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   arm_i, stop_i    : raw control bits from software
//   arm_p_o, stop_p_o: one-cycle pulses on a 0->1 transition
// No pulse is emitted in the first cycle after reset: a bit already high while
// reset is released must not look like a fresh edge.
module snap_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arm_i,
    input  logic stop_i,
    output logic arm_p_o,
    output logic stop_p_o
);
    logic arm_q, stop_q, primed_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arm_q    <= 1'b0;
            stop_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            arm_q    <= arm_i;
            stop_q   <= stop_i;
            primed_q <= 1'b1;
        end
    end

    assign arm_p_o  = primed_q & arm_i & ~arm_q;
    assign stop_p_o = primed_q & stop_i & ~stop_q;
endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arms from software, waits for an immediate or
// external trigger, writes 2^ADDR_W consecutive valid samples into the BRAM and
// reports done/busy/triggered flags plus the word count.
//   user_clk, user_rst : clock, asynchronous active-high reset
//   bus                : control, sample, BRAM write and status signals
module snap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 64
) (
    input  logic               user_clk,
    input  logic               user_rst,
    snap_capture_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] LastIdx = {1'b0, {ADDR_W{1'b1}}};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              trig_q, trig_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic [31:0]       status_q, status_d;
    logic              arm_p, stop_p, trig_cond, accept;

    logic unused_ctrl;
    assign unused_ctrl = ^bus.ctrl_in[31:3];

    snap_edge_det u_edge_det (
        .clk_i    (user_clk),
        .rst_i    (user_rst),
        .arm_i    (bus.ctrl_in[CTRL_ARM]),
        .stop_i   (bus.ctrl_in[CTRL_STOP]),
        .arm_p_o  (arm_p),
        .stop_p_o (stop_p)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        trig_d    = trig_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        accept    = 1'b0;
        trig_cond = ~bus.ctrl_in[CTRL_TSRC] | bus.trig_in;

        if (arm_p) begin
            state_d = StArmed;
            count_d = '0;
            trig_d  = 1'b0;
        end else if (stop_p && (state_q == StArmed || state_q == StCapture)) begin
            // Any sample offered this cycle is dropped.
            state_d = StDone;
        end else begin
            case (state_q)
                StArmed: begin
                    if (trig_cond) begin
                        state_d = StCapture;
                        trig_d  = 1'b1;
                        accept  = bus.din_valid;
                    end
                end
                StCapture: accept = bus.din_valid;
                default: ;
            endcase

            if (accept) begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                data_d  = bus.din;
                count_d = count_q + 1'b1;
                if (count_q == LastIdx) begin
                    state_d = StDone;
                end
            end
        end

        // Status tracks the next state so it updates together with the write port.
        status_d              = '0;
        status_d[ADDR_W:0]    = count_d;
        status_d[ST_DONE]     = (state_d == StDone);
        status_d[ST_BUSY]     = (state_d == StArmed) || (state_d == StCapture);
        status_d[ST_TRIG]     = trig_d;
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            trig_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            trig_q   <= trig_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            status_q <= status_d;
        end
    end

    assign bus.bram_addr  = addr_q;
    assign bus.bram_data  = data_q;
    assign bus.bram_we    = we_q;
    assign bus.status_out = status_q;
endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Self-checking bench for snap_capture_ctrl with ADDR_W=4 (16-word capture).
module tb_snap_capture_ctrl;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 64;

    logic user_clk = 1'b0;
    logic user_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 user_clk = ~user_clk;

    snap_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    snap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0]   ctrl;
        logic          trig;
        logic          valid;
        logic [DW-1:0] din;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [31:0]   exp_status;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs are already set; advance one edge and settle.
    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] c, input logic t, input logic v,
                         input logic [DW-1:0] d);
        bus.ctrl_in   = c;
        bus.trig_in   = t;
        bus.din_valid = v;
        bus.din       = d;
    endtask

    initial begin
        int wr_cnt;
        int done_cyc;
        int exp_idx;

        // ctrl, trig, valid, din | we, addr, data, status
        vecs[0]  = '{32'h2, 1'b0, 1'b1, 64'hAA, 1'b0, 4'h0, 64'h00, 32'h0000_0000};
        vecs[1]  = '{32'h3, 1'b0, 1'b1, 64'hAB, 1'b0, 4'h0, 64'h00, 32'h4000_0000};
        vecs[2]  = '{32'h3, 1'b0, 1'b1, 64'hAC, 1'b0, 4'h0, 64'h00, 32'h4000_0000};
        vecs[3]  = '{32'h3, 1'b0, 1'b1, 64'hAD, 1'b0, 4'h0, 64'h00, 32'h4000_0000};
        vecs[4]  = '{32'h3, 1'b0, 1'b1, 64'hAE, 1'b0, 4'h0, 64'h00, 32'h4000_0000};
        vecs[5]  = '{32'h3, 1'b1, 1'b1, 64'h55, 1'b1, 4'h0, 64'h55, 32'h6000_0001};
        vecs[6]  = '{32'h3, 1'b0, 1'b0, 64'h66, 1'b0, 4'h0, 64'h55, 32'h6000_0001};
        vecs[7]  = '{32'h3, 1'b0, 1'b1, 64'h77, 1'b1, 4'h1, 64'h77, 32'h6000_0002};
        vecs[8]  = '{32'h7, 1'b0, 1'b1, 64'h88, 1'b0, 4'h1, 64'h77, 32'hA000_0002};
        vecs[9]  = '{32'h7, 1'b0, 1'b1, 64'h99, 1'b0, 4'h1, 64'h77, 32'hA000_0002};
        vecs[10] = '{32'h6, 1'b0, 1'b1, 64'h9A, 1'b0, 4'h1, 64'h77, 32'hA000_0002};
        vecs[11] = '{32'h7, 1'b0, 1'b1, 64'h9B, 1'b0, 4'h1, 64'h77, 32'h4000_0000};
        vecs[12] = '{32'h7, 1'b1, 1'b0, 64'h9C, 1'b0, 4'h1, 64'h77, 32'h6000_0000};
        vecs[13] = '{32'h2, 1'b0, 1'b1, 64'hC3, 1'b1, 4'h0, 64'hC3, 32'h6000_0001};
        vecs[14] = '{32'h7, 1'b0, 1'b1, 64'hD4, 1'b0, 4'h0, 64'hC3, 32'h4000_0000};
        vecs[15] = '{32'h6, 1'b0, 1'b1, 64'hD5, 1'b0, 4'h0, 64'hC3, 32'h4000_0000};
        vecs[16] = '{32'h2, 1'b0, 1'b1, 64'hD6, 1'b0, 4'h0, 64'hC3, 32'h4000_0000};
        vecs[17] = '{32'h6, 1'b0, 1'b1, 64'hD7, 1'b0, 4'h0, 64'hC3, 32'h8000_0000};
        vecs[18] = '{32'h6, 1'b1, 1'b1, 64'hD8, 1'b0, 4'h0, 64'hC3, 32'h8000_0000};

        drive(32'h0, 1'b0, 1'b0, '0);
        #12;
        chk("rst_we", {63'd0, bus.bram_we}, 64'd0);
        chk("rst_status", {32'd0, bus.status_out}, 64'd0);
        chk("rst_addr", {60'd0, bus.bram_addr}, 64'd0);
        @(negedge user_clk);
        user_rst = 1'b0;
        repeat (3) tick();

        // External trigger, stop, re-arm and arm+stop collision.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].ctrl, vecs[i].trig, vecs[i].valid, vecs[i].din);
            tick();
            chk($sformatf("v%0d_we", i), {63'd0, bus.bram_we}, {63'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_addr", i), {60'd0, bus.bram_addr}, {60'd0, vecs[i].exp_addr});
            chk($sformatf("v%0d_data", i), bus.bram_data, vecs[i].exp_data);
            chk($sformatf("v%0d_status", i), {32'd0, bus.status_out},
                {32'd0, vecs[i].exp_status});
        end

        // Full immediate capture, din = index.
        drive(32'h0, 1'b0, 1'b0, '0);
        tick();
        drive(32'h1, 1'b0, 1'b0, '0);
        tick();
        chk("full_armed", {32'd0, bus.status_out}, 64'h4000_0000);
        for (int i = 0; i < 16; i++) begin
            drive(32'h1, 1'b0, 1'b1, DW'(i));
            tick();
            chk($sformatf("full_we%0d", i), {63'd0, bus.bram_we}, 64'd1);
            chk($sformatf("full_addr%0d", i), {60'd0, bus.bram_addr}, 64'(i));
            chk($sformatf("full_data%0d", i), bus.bram_data, 64'(i));
        end
        chk("full_status", {32'd0, bus.status_out}, 64'hA000_0010);
        repeat (2) begin
            tick();
            chk("full_post_we", {63'd0, bus.bram_we}, 64'd0);
            chk("full_post_status", {32'd0, bus.status_out}, 64'hA000_0010);
        end

        // din_valid toggling 1,0,1,0...
        drive(32'h0, 1'b0, 1'b0, '0);
        tick();
        drive(32'h1, 1'b0, 1'b0, '0);
        tick();
        wr_cnt   = 0;
        done_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            drive(32'h1, 1'b0, (c % 2) == 0, DW'(100 + c));
            tick();
            if (bus.bram_we) begin
                chk("tog_addr", {60'd0, bus.bram_addr}, 64'(wr_cnt));
                chk("tog_data", bus.bram_data, 64'(100 + c));
                wr_cnt++;
            end
            if (bus.status_out[31] && done_cyc < 0) done_cyc = c;
        end
        chk("tog_writes", 64'(wr_cnt), 64'd16);
        chk("tog_done_cycle", 64'(done_cyc), 64'd30);
        chk("tog_status", {32'd0, bus.status_out}, 64'hA000_0010);

        // Stop after 6 writes.
        drive(32'h0, 1'b0, 1'b0, '0);
        tick();
        drive(32'h1, 1'b0, 1'b0, '0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(32'h1, 1'b0, 1'b1, DW'(i));
            tick();
        end
        chk("stop_last_addr", {60'd0, bus.bram_addr}, 64'd5);
        drive(32'h5, 1'b0, 1'b1, 64'hFF);
        tick();
        chk("stop_we", {63'd0, bus.bram_we}, 64'd0);
        chk("stop_status", {32'd0, bus.status_out}, 64'hA000_0006);
        wr_cnt = 0;
        repeat (4) begin
            tick();
            if (bus.bram_we) wr_cnt++;
        end
        chk("stop_no_writes", 64'(wr_cnt), 64'd0);
        chk("stop_status_hold", {32'd0, bus.status_out}, 64'hA000_0006);

        // Re-arm at count 9.
        drive(32'h0, 1'b0, 1'b0, '0);
        tick();
        drive(32'h1, 1'b0, 1'b0, '0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(32'h1, 1'b0, 1'b1, DW'(i));
            tick();
        end
        chk("rearm_pre", {32'd0, bus.status_out}, 64'h6000_0009);
        drive(32'h0, 1'b0, 1'b0, '0);
        tick();
        drive(32'h1, 1'b0, 1'b1, 64'hEE);
        tick();
        chk("rearm_status", {32'd0, bus.status_out}, 64'h4000_0000);
        chk("rearm_we", {63'd0, bus.bram_we}, 64'd0);
        drive(32'h1, 1'b0, 1'b1, 64'hE0);
        tick();
        chk("rearm_addr", {60'd0, bus.bram_addr}, 64'd0);
        chk("rearm_data", bus.bram_data, 64'hE0);
        chk("rearm_we1", {63'd0, bus.bram_we}, 64'd1);

        // Asynchronous reset mid-capture; arm bit held high throughout.
        tick();
        #2;
        user_rst = 1'b1;
        #1;
        chk("arst_we", {63'd0, bus.bram_we}, 64'd0);
        chk("arst_addr", {60'd0, bus.bram_addr}, 64'd0);
        chk("arst_data", bus.bram_data, 64'd0);
        chk("arst_status", {32'd0, bus.status_out}, 64'd0);
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        user_rst = 1'b0;
        drive(32'h1, 1'b1, 1'b1, 64'h123);
        wr_cnt  = 0;
        exp_idx = 0;
        repeat (5) begin
            tick();
            if (bus.bram_we) wr_cnt++;
            if (bus.status_out != 32'h0) exp_idx++;
        end
        chk("arst_no_writes", 64'(wr_cnt), 64'd0);
        chk("arst_idle_status", 64'(exp_idx), 64'd0);
        drive(32'h0, 1'b0, 1'b0, '0);
        tick();
        drive(32'h3, 1'b0, 1'b0, '0);
        tick();
        chk("arst_rearm", {32'd0, bus.status_out}, 64'h4000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
